rvv_backend_rs_credit_ctrl: RTL

RVV_BACKEND_RS_CREDIT_CTRL -- requirements
Module: rvv_backend_rs_credit_ctrl

---
 rtl/rvv_backend_rs_credit_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rvv_backend_rs_credit_ctrl.sv
// Credit controller for a vector reservation station.
// Tracks free RS entries and gives dispatch a per-lane ready. Dispatch lanes
// fill contiguously from lane 0, so lane i is ready iff more than i credits
// are free. A trap flush parks the controller in FLUSH for FLUSH_LAT cycles,
// restores full credit and pulses flush_done on the way out.
//
// Optional feature: define RVV_RS_CREDIT_CHECK_EN to build the sticky
// protocol checker behind credit_err. It flags pushes without ready,
// non-contiguous push patterns and credit overflow. With the macro undefined,
// credit_err is tied low and no checking logic is built.

`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif

module rvv_backend_rs_credit_ctrl #(
    parameter int unsigned RS_DEPTH  = 8,
    parameter int unsigned NUM_DP    = `NUM_DP_UOP,
    parameter int unsigned NUM_POP   = 2,
    parameter int unsigned FLUSH_LAT = 2,
    localparam int unsigned CW = $clog2(RS_DEPTH + 1),
    localparam int unsigned FW = $clog2(FLUSH_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_DP-1:0] rs_valid_dp2rs,
    output logic [NUM_DP-1:0] rs_ready_rs2dp,
    input  logic [NUM_POP-1:0] pop_valid_rs2ex,
    input  logic              trap_flush_rvv,
    output logic              flush_done,
    output logic [CW-1:0]     credit_cnt,
    output logic              credit_err
);

    // One spare bit so the credit arithmetic can see overflow past RS_DEPTH.
    localparam int unsigned NW = CW + 1;

    typedef enum logic {StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]   credit_d;

    logic [NUM_DP-1:0] push_ok;
    logic [NW-1:0]     push_num;
    logic [NW-1:0]     pop_num;
    logic [NW-1:0]     credit_sum;
    logic              credit_sat;

    // Lane i may accept a push only when more than i credits are free.
    always_comb begin
        rs_ready_rs2dp = '0;
        for (int i = 0; i < NUM_DP; i++) begin
            rs_ready_rs2dp[i] = (state_q == StRun) && ({1'b0, credit_cnt} > NW'(i));
        end
    end

    // Count accepted pushes and departing entries, then form the next credit.
    always_comb begin
        push_ok  = rs_valid_dp2rs & rs_ready_rs2dp;
        push_num = '0;
        pop_num  = '0;
        for (int i = 0; i < NUM_DP; i++) begin
            push_num = push_num + NW'(push_ok[i]);
        end
        for (int i = 0; i < NUM_POP; i++) begin
            pop_num = pop_num + NW'(pop_valid_rs2ex[i]);
        end
        credit_sum = {1'b0, credit_cnt} - push_num + pop_num;
        credit_sat = credit_sum > NW'(RS_DEPTH);
    end

    // Next-state logic: RUN tracks credit, FLUSH holds full credit and counts down.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        credit_d    = credit_cnt;
        flush_done  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (trap_flush_rvv) begin
                    // Same-cycle pushes and pops are dropped with the flushed work.
                    state_d     = StFlush;
                    flush_cnt_d = FW'(FLUSH_LAT - 1);
                    credit_d    = CW'(RS_DEPTH);
                end else if (credit_sat) begin
                    credit_d = CW'(RS_DEPTH);
                end else begin
                    credit_d = credit_sum[CW-1:0];
                end
            end
            StFlush: begin
                credit_d = CW'(RS_DEPTH);
                if (trap_flush_rvv) begin
                    flush_cnt_d = FW'(FLUSH_LAT - 1);
                end else if (flush_cnt_q == '0) begin
                    state_d    = StRun;
                    flush_done = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State, flush counter and credit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            credit_cnt  <= CW'(RS_DEPTH);
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            credit_cnt  <= credit_d;
        end
    end

`ifdef RVV_RS_CREDIT_CHECK_EN
    logic err_event;
    logic noncontig;

    // Protocol violations observed during normal RUN operation.
    always_comb begin
        noncontig = 1'b0;
        for (int i = 1; i < NUM_DP; i++) begin
            if (rs_valid_dp2rs[i] && !rs_valid_dp2rs[i-1]) begin
                noncontig = 1'b1;
            end
        end
        err_event = (state_q == StRun) && !trap_flush_rvv &&
                    ((|(rs_valid_dp2rs & ~rs_ready_rs2dp)) || noncontig || credit_sat);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_err <= 1'b0;
        end else if (err_event) begin
            credit_err <= 1'b1;
        end
    end
`else
    assign credit_err = 1'b0;
`endif

    // Credit never exceeds the RS size; flush_done only ever fires from FLUSH.
    assert property (@(posedge clk) disable iff (rst) credit_cnt <= CW'(RS_DEPTH));
    assert property (@(posedge clk) disable iff (rst) flush_done |-> (state_q == StFlush));

endmodule
